// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the result-to-display path: FSM states,
// BCD nibble type and active-low segment patterns ({g,f,e,d,c,b,a}).
package calc_disp_pkg;

    localparam int RESULT_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam logic [RESULT_W-1:0] MAX_DISPLAY = 14'd9999;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Result/control/display bundle between the calculator side and the scan controller.
interface display_scan_ctrl_if;
    import calc_disp_pkg::*;

    logic [RESULT_W-1:0] result_in;
    logic                load;
    logic                blank_lz;
    logic                busy;
    logic                done;
    logic [6:0]          seg;
    logic [3:0]          an;

    modport master (
        output result_in, load, blank_lz,
        input  busy, done, seg, an
    );

    modport slave (
        input  result_in, load, blank_lz,
        output busy, done, seg, an
    );

endinterface

// File: rtl/bcd_seg_decoder.sv
// One BCD nibble to an active-low 7-segment pattern; dash overrides blank,
// and non-decimal nibbles show nothing.
module bcd_seg_decoder
    import calc_disp_pkg::*;
(
    input  bcd_t       digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (dash) begin
            seg = SEG_DASH;
        end else if (!blank && (digit <= 4'd9)) begin
            seg = SEG_DIGIT[digit];
        end
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// Captures a binary result, converts it to four BCD digits by double-dabble,
// then multiplexes the committed digits onto a common-anode 4-digit display.
module display_scan_ctrl
    import calc_disp_pkg::*;
#(
    parameter int WIDTH       = RESULT_W,
    parameter int REFRESH_DIV = 100000
) (
    input  logic                clk,
    input  logic                rst,
    display_scan_ctrl_if.slave  bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t           state_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [WIDTH-1:0] bin_reg;
    logic [15:0]      bcd_reg;
    logic [3:0]       step_reg;
    logic             ovf_pending_reg;
    bcd_t             disp_digit_reg [4];
    logic             ovf_reg;

    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       scan_idx_reg;
    logic [3:0]       an_reg;
    logic [6:0]       seg_reg;

    logic [15:0]        bcd_adj;
    logic [WIDTH+15:0]  shifted_next;
    logic [3:0]         blank_next;
    logic [6:0]         dec_seg [4];

    // Add-3 correction on every nibble before the shift of each step.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
        end
    endgenerate

    assign shifted_next = {bcd_adj, bin_reg} << 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            bin_reg         <= '0;
            bcd_reg         <= '0;
            step_reg        <= '0;
            ovf_pending_reg <= 1'b0;
            ovf_reg         <= 1'b0;
            for (int i = 0; i < 4; i++) disp_digit_reg[i] <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.load) begin
                        bin_reg         <= bus.result_in;
                        bcd_reg         <= '0;
                        ovf_pending_reg <= (bus.result_in > MAX_DISPLAY);
                        step_reg        <= 4'(WIDTH - 1);
                        busy_reg        <= 1'b1;
                        state_reg       <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    {bcd_reg, bin_reg} <= shifted_next;
                    step_reg           <= step_reg - 4'd1;
                    if (step_reg == 4'd0) state_reg <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    for (int i = 0; i < 4; i++) disp_digit_reg[i] <= bcd_reg[4*i +: 4];
                    ovf_reg   <= ovf_pending_reg;
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Zero-run from the thousands digit downwards; units always stay lit.
    always_comb begin
        blank_next    = 4'b0000;
        blank_next[3] = bus.blank_lz && !ovf_reg && (disp_digit_reg[3] == 4'd0);
        blank_next[2] = blank_next[3] && (disp_digit_reg[2] == 4'd0);
        blank_next[1] = blank_next[2] && (disp_digit_reg[1] == 4'd0);
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_dec
            bcd_seg_decoder u_dec (
                .digit (disp_digit_reg[gi]),
                .blank (blank_next[gi]),
                .dash  (ovf_reg),
                .seg   (dec_seg[gi])
            );
        end
    endgenerate

    // Scan index 0 is the thousands digit, so the digit slot is reversed.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            scan_idx_reg <= 2'd0;
            an_reg       <= 4'b1111;
            seg_reg      <= SEG_BLANK;
        end else begin
            if (cnt_reg == CNT_MAX) begin
                cnt_reg      <= '0;
                scan_idx_reg <= scan_idx_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            an_reg  <= ~(4'b1000 >> scan_idx_reg);
            seg_reg <= dec_seg[2'd3 - scan_idx_reg];
        end
    end

    assign bus.busy = busy_reg;
    assign bus.done = done_reg;
    assign bus.seg  = seg_reg;
    assign bus.an   = an_reg;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 4-cycle digit slot.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [3:0] cap_an  [0:47];
    logic [6:0] cap_seg [0:47];
    bit         cap_ok;

    display_scan_ctrl_if dif ();

    display_scan_ctrl #(.WIDTH(14), .REFRESH_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            10: return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    // All stimulus tasks start and end just after a falling edge.
    task automatic load_value(input int v);
        dif.result_in = 14'(v);
        dif.load = 1'b1;
        @(negedge clk);
        dif.load = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = -1;
        for (int j = 1; j <= 40; j++) begin
            if (dif.done) begin
                n = j;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Aligns to the first cycle of a thousands slot, then records n cycles.
    task automatic capture_cycles(input int n);
        logic [3:0] prev;
        cap_ok = 1'b0;
        prev = dif.an;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (prev != 4'b0111 && dif.an == 4'b0111) begin
                cap_ok = 1'b1;
                break;
            end
            prev = dif.an;
        end
        if (cap_ok) begin
            for (int c = 0; c < n; c++) begin
                cap_an[c]  = dif.an;
                cap_seg[c] = dif.seg;
                if (c < n - 1) @(negedge clk);
            end
        end
    endtask

    task automatic compare_frame(input string name, input int d3, input int d2, input int d1, input int d0);
        logic [6:0] e [4];
        logic [3:0] ea;
        e[0] = seg_of(d3); e[1] = seg_of(d2); e[2] = seg_of(d1); e[3] = seg_of(d0);
        checks++;
        if (!cap_ok) begin
            errors++;
            $display("FAIL %s align: no thousands slot start within 40 cycles", name);
        end else begin
            for (int c = 0; c < 16; c++) begin
                ea = ~(4'b1000 >> (c / 4));
                checks++;
                if (cap_an[c] !== ea || cap_seg[c] !== e[c / 4]) begin
                    errors++;
                    $display("FAIL %s cycle %0d: an=%b seg=%b, required an=%b seg=%b",
                             name, c, cap_an[c], cap_seg[c], ea, e[c / 4]);
                end
            end
        end
        $display("frame %s: %0d %0d %0d %0d", name, d3, d2, d1, d0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dif.load = 1'b0;
        dif.result_in = '0;
        dif.blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dif.busy !== 1'b0 || dif.done !== 1'b0 || dif.an !== 4'b1111 || dif.seg !== 7'b1111111) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b an=%b seg=%b, required 0 0 1111 1111111",
                     dif.busy, dif.done, dif.an, dif.seg);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (dif.an !== 4'b0111 || dif.seg !== 7'b1000000) begin
            errors++;
            $display("FAIL reset_first_slot: an=%b seg=%b, required 0111 1000000", dif.an, dif.seg);
        end
        $display("reset: done");
    endtask

    task automatic test_latency_9325();
        load_value(9325);
        for (int j = 1; j <= 20; j++) begin
            checks++;
            if (dif.busy !== (j <= 15) || dif.done !== (j == 16)) begin
                errors++;
                $display("FAIL latency cycle %0d: busy=%b done=%b, required busy=%b done=%b",
                         j, dif.busy, dif.done, (j <= 15), (j == 16));
            end
            if (j < 20) @(negedge clk);
        end
        capture_cycles(16);
        compare_frame("9325", 9, 3, 2, 5);
    endtask

    task automatic test_blanking();
        int n;
        dif.blank_lz = 1'b1;
        load_value(7);
        wait_done(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL blank_done: latency=%0d, required 16", n);
        end
        capture_cycles(16);
        compare_frame("7_lz", 11, 11, 11, 7);
        dif.blank_lz = 1'b0;
        capture_cycles(16);
        compare_frame("7_nolz", 0, 0, 0, 7);
        dif.blank_lz = 1'b1;
        load_value(205);
        wait_done(n);
        capture_cycles(16);
        compare_frame("205_lz", 11, 2, 0, 5);
        dif.blank_lz = 1'b0;
    endtask

    task automatic test_overflow();
        int n;
        load_value(16383);
        wait_done(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL ovf_done: latency=%0d, required 16", n);
        end
        capture_cycles(16);
        compare_frame("16383", 10, 10, 10, 10);
        load_value(10);
        wait_done(n);
        capture_cycles(16);
        compare_frame("10", 0, 0, 1, 0);
        load_value(10000);
        wait_done(n);
        capture_cycles(16);
        compare_frame("10000", 10, 10, 10, 10);
        load_value(9999);
        wait_done(n);
        capture_cycles(16);
        compare_frame("9999", 9, 9, 9, 9);
    endtask

    task automatic test_back_to_back();
        int dones = 0;
        load_value(1234);
        @(negedge clk);
        @(negedge clk);
        load_value(5678);
        for (int j = 0; j < 40; j++) begin
            if (dif.done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL b2b_done_count: dones=%0d, required 1", dones);
        end
        capture_cycles(16);
        compare_frame("b2b", 1, 2, 3, 4);
        // load landing exactly in the commit cycle must also be dropped
        dones = 0;
        load_value(4444);
        repeat (14) @(negedge clk);
        load_value(8888);
        for (int j = 0; j < 40; j++) begin
            if (dif.done) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL commit_load_count: dones=%0d, required 1", dones);
        end
        capture_cycles(16);
        compare_frame("commit_load", 4, 4, 4, 4);
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        int n;
        load_value(4321);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dif.busy !== 1'b0 || dif.an !== 4'b1111 || dif.seg !== 7'b1111111 || dif.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outputs: busy=%b done=%b an=%b seg=%b, required 0 0 1111 1111111",
                     dif.busy, dif.done, dif.an, dif.seg);
        end
        rst = 1'b0;
        for (int j = 0; j < 30; j++) begin
            if (dif.done || dif.busy) dones++;
            @(negedge clk);
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midrst_no_done: busy/done cycles=%0d, required 0", dones);
        end
        capture_cycles(16);
        compare_frame("after_rst", 0, 0, 0, 0);
        load_value(4321);
        wait_done(n);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL midrst_reload: latency=%0d, required 16", n);
        end
        capture_cycles(16);
        compare_frame("4321", 4, 3, 2, 1);
    endtask

    task automatic test_scan_wrap();
        logic [3:0] ea;
        capture_cycles(48);
        checks++;
        if (!cap_ok) begin
            errors++;
            $display("FAIL wrap_align: no thousands slot start within 40 cycles");
        end else begin
            for (int c = 0; c < 48; c++) begin
                ea = ~(4'b1000 >> ((c / 4) % 4));
                checks++;
                if (cap_an[c] !== ea || $countones(~cap_an[c]) != 1) begin
                    errors++;
                    $display("FAIL wrap cycle %0d: an=%b, required %b", c, cap_an[c], ea);
                end
            end
        end
        $display("scan_wrap: 3 frames");
    endtask

    initial begin
        test_reset();
        test_latency_9325();
        test_blanking();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_scan_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
